// File: rtl/mcpu_prog_loader_if.sv
// Byte-stream, RAM write port and CPU boot control bundle for the MCPU program loader.
interface mcpu_prog_loader_if #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 8
) ();
  logic                 start;
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic                 byte_ready;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 cpu_hold;
  logic                 done;
  logic                 err;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/mcpu_prog_loader.sv
// Boot loader: assembles a LEN/words/CHK byte image into MCPU RAM and holds the CPU until done.
// Optional checksum stage enabled by defining MCPU_LOADER_CHKSUM_EN.
module mcpu_prog_loader #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned RAM_SIZE  = 256
) (
  input logic              clk,
  input logic              reset,
  mcpu_prog_loader_if.slave bus
);

  // Count must hold RAM_SIZE itself, since LEN=0 encodes a full RAM.
  localparam int unsigned CNT_W = $clog2(RAM_SIZE) + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_WR   = 3'd4,
    S_CHK  = 3'd5,
    S_DONE = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           hi_q, hi_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 ready_q, ready_d;
  logic                 we_q, we_d;
  logic                 hold_q, hold_d;
  logic                 done_q, done_d;
`ifdef MCPU_LOADER_CHKSUM_EN
  logic [7:0]           chk_q, chk_d;
  logic                 err_q, err_d;
`endif
  logic                 xfer;

  assign xfer = bus.byte_valid & ready_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
`ifdef MCPU_LOADER_CHKSUM_EN
    chk_d   = chk_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_LEN;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          addr_d  = '0;
`ifdef MCPU_LOADER_CHKSUM_EN
          chk_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_LEN: begin
        if (xfer) begin
          cnt_d   = (bus.byte_in == 8'd0) ? CNT_W'(RAM_SIZE) : CNT_W'(bus.byte_in);
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_d    = bus.byte_in;
`ifdef MCPU_LOADER_CHKSUM_EN
          chk_d   = chk_q ^ bus.byte_in;
`endif
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          wdata_d = WORD_SIZE'({hi_q, bus.byte_in});
`ifdef MCPU_LOADER_CHKSUM_EN
          chk_d   = chk_q ^ bus.byte_in;
`endif
          state_d = S_WR;
        end
      end
      S_WR: begin
        // Address wraps naturally after a full-RAM image.
        addr_d = addr_q + ADDR_SIZE'(1);
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
`ifdef MCPU_LOADER_CHKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
`endif
        end else begin
          state_d = S_HI;
        end
      end
`ifdef MCPU_LOADER_CHKSUM_EN
      S_CHK: begin
        if (xfer) begin
          state_d = S_DONE;
          if (bus.byte_in == chk_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and write strobe are registered from the state being entered.
  always_comb begin
    ready_d = (state_d == S_LEN) || (state_d == S_HI) ||
              (state_d == S_LO)  || (state_d == S_CHK);
    we_d    = (state_d == S_WR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef MCPU_LOADER_CHKSUM_EN
      chk_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef MCPU_LOADER_CHKSUM_EN
      chk_q   <= chk_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cpu_hold   = hold_q;
  assign bus.done       = done_q;
`ifdef MCPU_LOADER_CHKSUM_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule
